// File: rtl/axis_delay_pkg.sv
// Shared helpers for the variable sample delay line.
// Address sizing, delay clamping and prefill policy encodings.
package axis_delay_pkg;

    localparam int PREFILL_ZERO = 0;
    localparam int PREFILL_DROP = 1;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int clamp_delay(input int req, input int max_delay);
        return (req >= max_delay) ? max_delay - 1 : req;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// Written to map onto block RAM; contents are never reset.
module sdp_ram
    import axis_delay_pkg::*;
#(
    parameter  int DW    = 32,
    parameter  int DEPTH = 512,
    localparam int AW    = addr_w(DEPTH)
) (
    input  logic          i_clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/axis_var_delay.sv
// Runtime-programmable AXI-Stream sample delay with backpressure,
// flush and selectable prefill policy.
module axis_var_delay
    import axis_delay_pkg::*;
#(
    parameter  int PAR_DATA_WIDTH   = 32,
    parameter  int PAR_MAX_DELAY    = 512,
    parameter  int PAR_INIT_DELAY   = 64,
    parameter  int PAR_PREFILL_MODE = 0,
    localparam int ADDR_W           = addr_w(PAR_MAX_DELAY)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic [PAR_DATA_WIDTH-1:0] s_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [PAR_DATA_WIDTH-1:0] m_axis_tdata,
    input  logic [ADDR_W:0]           i_delay,
    input  logic                      i_delay_load,
    input  logic                      i_flush,
    output logic                      o_filled
);

    localparam logic [ADDR_W-1:0] INIT_D =
        ADDR_W'(clamp_delay(PAR_INIT_DELAY, PAR_MAX_DELAY));
    localparam bit DROP = (PAR_PREFILL_MODE == PREFILL_DROP);

    logic                      advance;
    logic                      accept;
    logic                      prefill;
    logic                      restart;
    logic [ADDR_W-1:0]         wr_ptr;
    logic [ADDR_W-1:0]         rd_addr;
    logic [ADDR_W-1:0]         dly;
    logic [ADDR_W-1:0]         dly_req;
    logic [ADDR_W-1:0]         fill;
    logic [ADDR_W-1:0]         fill_nxt;
    logic [PAR_DATA_WIDTH-1:0] ram_q;
    logic [PAR_DATA_WIDTH-1:0] byp_q;
    logic                      s1_valid;
    logic                      s1_zero;
    logic                      s1_byp;

    assign advance       = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = advance && !i_flush && !i_delay_load;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign prefill       = fill < dly;
    assign restart       = i_flush || i_delay_load;
    assign rd_addr       = wr_ptr - dly;
    assign fill_nxt      = (accept && prefill) ? fill + 1'b1 : fill;
    assign dly_req       = ADDR_W'(clamp_delay(int'(i_delay), PAR_MAX_DELAY));

    sdp_ram #(
        .DW    (PAR_DATA_WIDTH),
        .DEPTH (PAR_MAX_DELAY)
    ) u_ram (
        .i_clk   (i_clk),
        .wr_en   (accept),
        .wr_addr (wr_ptr),
        .wr_data (s_axis_tdata),
        .rd_en   (accept),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr        <= '0;
            fill          <= '0;
            dly           <= INIT_D;
            o_filled      <= 1'b0;
            s1_valid      <= 1'b0;
            s1_zero       <= 1'b0;
            s1_byp        <= 1'b0;
            byp_q         <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (advance) begin
                s1_valid <= accept && !(prefill && DROP);
                s1_zero  <= prefill;
                // Bypass choice is captured per sample so a later load
                // cannot redirect a sample already in flight.
                s1_byp   <= (dly == '0);
                if (accept) byp_q <= s_axis_tdata;
                m_axis_tvalid <= s1_valid;
                m_axis_tdata  <= s1_zero ? '0 : (s1_byp ? byp_q : ram_q);
            end
            if (i_flush) begin
                s1_valid      <= 1'b0;
                m_axis_tvalid <= 1'b0;
            end
            if (i_delay_load) dly <= dly_req;
            fill     <= restart ? '0 : fill_nxt;
            o_filled <= !restart && (fill_nxt == dly);
        end
    end

endmodule

// File: doc/axis_var_delay.md
# axis_var_delay

Runtime-programmable sample delay line for the AIS frame-detector datapath, successor to the fixed data delay. Delays an AXI-Stream sample stream by D accepted samples, where D is loaded at run time in the range 0..PAR_MAX_DELAY-1. Adds full backpressure, flush, and a selectable prefill policy. Sits between the sample front end and the correlator, where it aligns the data path to detector latency.

## Interface
- PAR_DATA_WIDTH, 32, sample width in bits.
- PAR_MAX_DELAY, 512, RAM depth. Must be a power of two, ≥ 2. ADDR_W = clog2(PAR_MAX_DELAY).
- PAR_INIT_DELAY, 64, delay value after reset.
- PAR_PREFILL_MODE, 0. 0 = emit zero-valued samples with valid during prefill. 1 = suppress output during prefill.

Ports:
- i_clk, in, 1, sole clock.
- i_rst_n, in, 1, synchronous active-low reset.
- s_axis_tvalid, in, 1, input sample valid.
- s_axis_tready, out, 1, input ready.
- s_axis_tdata, in, PAR_DATA_WIDTH, input sample.
- m_axis_tvalid, out, 1, output valid.
- m_axis_tready, in, 1, output ready.
- m_axis_tdata, out, PAR_DATA_WIDTH, delayed sample.
- i_delay, in, ADDR_W+1, requested delay. Values ≥ PAR_MAX_DELAY clamp to PAR_MAX_DELAY-1.
- i_delay_load, in, 1, single-cycle pulse that latches i_delay and restarts prefill.
- i_flush, in, 1, single-cycle pulse that empties the pipeline and restarts prefill.
- o_filled, out, 1, high once fill count equals the active delay.

## Operation
- Advance = !m_axis_tvalid || m_axis_tready. All pipeline registers use Advance as a global enable.
- s_axis_tready = Advance && !i_flush && !i_delay_load.
- Accept = s_axis_tvalid && s_axis_tready.
- On Accept:
  - RAM[wr_ptr] <= s_axis_tdata.
  - Read address = wr_ptr - D, mod PAR_MAX_DELAY.
  - wr_ptr increments and wraps at PAR_MAX_DELAY-1 → 0.
- D = 0: the RAM is bypassed. Stage 1 takes s_axis_tdata directly, so output equals input with pipeline latency only.
- Fill counter (ADDR_W bits):
  - Increments on Accept.
  - Saturates at D.
  - A sample is a prefill sample if the counter is < D at its Accept.
- Prefill samples:
  - Mode 0: valid propagates and data is forced to 0.
  - Mode 1: valid is dropped. RAM is still written and the pointer still advances.
- i_delay_load:
  - D <= clamp(i_delay).
  - Fill counter <= 0.
  - Samples already in the pipeline complete normally.
  - Takes effect from the next Accept.
- i_flush:
  - Stage-1 and output valids <= 0.
  - Fill counter <= 0.
  - wr_ptr and D are unchanged.
  - Flush in the same cycle as load: both actions apply.
- Stale RAM contents are never emitted; the fill counter guarantees this after reset, flush or load.

## Timing
- Reset values:
  - wr_ptr = 0, fill = 0, D = PAR_INIT_DELAY.
  - m_axis_tvalid = 0, m_axis_tdata = 0, o_filled = 0.
  - s_axis_tready = 1 in the first cycle after reset is released.
  - RAM contents are not reset.
- Latency: a sample accepted in cycle t appears at the output in cycle t+2, provided Advance holds in t+1. Throughput is one sample per cycle.
- Stage 1 is the RAM registered read or the D=0 bypass register, plus the valid/prefill flag. Stage 2 is the output register. Both hold while Advance = 0.
- m_axis_tdata and m_axis_tvalid stay stable while m_axis_tvalid && !m_axis_tready.
- o_filled is registered. It rises the cycle after the Accept that brings fill to D, and falls the cycle after a load or flush.
- Reset asserted mid-stream: all state returns to reset values on the next edge, and any in-flight output is discarded.
- Load or flush in a cycle where m_axis_tready = 0: no input is accepted, and stage-1/output contents follow their flush rules.

## Structure
- Shared package axis_delay_pkg holds:
  - ADDR_W computation function.
  - Delay clamp function.
  - Prefill mode constants PREFILL_ZERO = 0 and PREFILL_DROP = 1.
- One sub-module, sdp_ram: simple dual-port RAM with PAR_DATA_WIDTH × PAR_MAX_DELAY, one write port, registered read with read enable, inferred as block RAM.
- Pointer, fill and pipeline control stay in axis_var_delay.

## Test plan
- Reset, D = 64 (init), mode 0, continuous ramp input 1,2,3…: first 64 outputs = 0 with valid; output 65 = 1; o_filled rises after input 64; each output lags its input by 2 cycles.
- Load D = 0, input 0xA5: output 0xA5 two cycles after acceptance; no prefill zeros.
- Mode 1, D = 3, input 10,11,12,13,14: outputs are 10,11 only; the first three accepted samples produce no valid.
- m_axis_tready toggled randomly, D = 5: output sequence matches a reference queue exactly; no drops or duplicates; data stable while stalled.
- Flush after 100 samples at D = 8: s_axis_tready = 0 in the flush cycle; m_axis_tvalid = 0 the next cycle; next 8 outputs are 0 (mode 0); o_filled falls and re-rises.
- i_delay = 600 with PAR_MAX_DELAY = 512: D clamps to 511; sample k reappears 511 accepts later; wr_ptr wraps from 511 to 0 without corruption.
